// File: rtl/clk_5mhz_gen_pkg.sv
// Shared helpers for the clock divider: high-phase length and counter sizing.
package clk_5mhz_gen_pkg;

    // Input cycles the rising-edge phase register stays high; the odd-ratio
    // half-cycle extension comes from the falling-edge register.
    function automatic int high_cycles(input int div);
        return (div + 1) / 2;
    endfunction

    // Bits needed to hold 0..max_value, never less than one.
    function automatic int width_for(input int max_value);
        return (max_value > 1) ? $clog2(max_value + 1) : 1;
    endfunction

endpackage

// File: rtl/clk_lock_cnt.sv
// Saturating count of completed output periods; raises locked after LOCK_CYCLES.
module clk_lock_cnt
    import clk_5mhz_gen_pkg::*;
#(
    parameter int LOCK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    output logic locked
);

    localparam int LW = width_for(LOCK_CYCLES);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CYCLES);

    if (LOCK_CYCLES < 1) begin : g_bad_lock_cycles
        $error("clk_lock_cnt: LOCK_CYCLES must be >= 1");
    end

    logic [LW-1:0] count;

    // NOTE: locked is registered with the count rather than decoded from it,
    // so it cannot glitch while several count bits change together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            locked <= 1'b0;
        end else if (tick && (count != LOCK_MAX)) begin
            count <= count + 1'b1;
            if (count == LOCK_MAX - 1'b1) begin
                locked <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_5mhz_gen.sv
// Integer clock divider with 50 % duty for odd or even ratios and a lock flag.
module clk_5mhz_gen
    import clk_5mhz_gen_pkg::*;
#(
    parameter int DIV         = 25,
    parameter int LOCK_CYCLES = 16
) (
    input  logic clk_in1,
    input  logic resetn,
    output logic clk_out1,
    output logic locked
);

    localparam int CW = width_for(DIV - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0] HIGH    = CW'(high_cycles(DIV));

    if (DIV < 2) begin : g_bad_div
        $error("clk_5mhz_gen: DIV must be >= 2");
    end

    logic [CW-1:0] cnt;
    logic          ph_p;
    logic          wrap;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // here samples the pre-edge value of cnt regardless of statement order.
    always_ff @(posedge clk_in1 or negedge resetn) begin
        if (!resetn) begin
            cnt  <= '0;
            ph_p <= 1'b0;
            wrap <= 1'b0;
        end else begin
            cnt  <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
            ph_p <= (cnt < HIGH);
            wrap <= (cnt == CNT_MAX);
        end
    end

    // The AND of two registers gives the extra half cycle of high time for odd
    // ratios without any counter decode reaching the clock output.
    if (DIV % 2 == 1) begin : g_odd
        logic ph_n;

        always_ff @(negedge clk_in1 or negedge resetn) begin
            if (!resetn) begin
                ph_n <= 1'b0;
            end else begin
                ph_n <= ph_p;
            end
        end

        assign clk_out1 = ph_p & ph_n;
    end else begin : g_even
        assign clk_out1 = ph_p;
    end

    // wrap is delayed one edge so each period is credited when the next begins.
    clk_lock_cnt #(
        .LOCK_CYCLES(LOCK_CYCLES)
    ) u_lock_cnt (
        .clk    (clk_in1),
        .rst_n  (resetn),
        .tick   (wrap),
        .locked (locked)
    );

endmodule

// File: tb/tb_clk_5mhz_gen.sv
// Directed scoreboard bench: default odd ratio (25) and an even ratio (4).
`timescale 1ns/100ps
module tb_clk_5mhz_gen;

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } exp_t;

    localparam time T = 8;

    logic clk = 1'b0;
    logic resetn_odd;
    logic resetn_even;
    logic clk_out_odd;
    logic locked_odd;
    logic clk_out_even;
    logic locked_even;
    logic sel_even;
    logic out_mux;
    logic lock_mux;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    time  t_e0;
    time  t_a;
    time  t_b;
    time  t_c;
    bit   found;
    bit   found_b;
    bit   found_c;
    bit   lock_low_seen;
    logic any_out;
    logic any_lock;

    always #4 clk = ~clk;

    assign out_mux  = sel_even ? clk_out_even : clk_out_odd;
    assign lock_mux = sel_even ? locked_even  : locked_odd;

    clk_5mhz_gen dut_odd (
        .clk_in1  (clk),
        .resetn   (resetn_odd),
        .clk_out1 (clk_out_odd),
        .locked   (locked_odd)
    );

    clk_5mhz_gen #(
        .DIV         (4),
        .LOCK_CYCLES (16)
    ) dut_even (
        .clk_in1  (clk),
        .resetn   (resetn_even),
        .clk_out1 (clk_out_even),
        .locked   (locked_even)
    );

    task automatic expect_val(input string tag, input longint exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic compare(input logic [63:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty: observed %0d required nothing", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                n_err++;
                $error("FAIL %s: observed %0d required %0d", e.tag, obs, e.exp);
            end
        end
    endtask

    function automatic logic [63:0] since_e0(input bit ok, input time t);
        return ok ? 64'(t - t_e0) : '1;
    endfunction

    // Polls 1 ns after every clock edge; outputs only move on edges, so the
    // edge time is the poll time minus 1 ns.
    task automatic wait_level(input logic lvl, input int max_half,
                              output time t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < max_half && !ok; i++) begin
            @(posedge clk or negedge clk);
            #1;
            if (lock_mux !== 1'b1) lock_low_seen = 1'b1;
            if (out_mux === lvl) begin
                ok = 1'b1;
                t  = $time - 1;
            end
        end
    endtask

    task automatic goto_edge(input int k);
        time target;
        target = t_e0 + T * k;
        while ($time < target) begin
            @(posedge clk or negedge clk);
            #1;
            if (lock_mux !== 1'b1) lock_low_seen = 1'b1;
        end
    endtask

    task automatic release_reset(input bit even);
        @(negedge clk);
        #1;
        if (even) resetn_even = 1'b1;
        else      resetn_odd  = 1'b1;
        @(posedge clk);
        t_e0 = $time;
        #1;
    endtask

    task automatic odd_first_edge_and_lock(input string pfx);
        expect_val({pfx, "_out_after_e0"}, 0);
        compare({63'b0, out_mux});
        wait_level(1'b1, 8, t_a, found);
        expect_val({pfx, "_first_rise_ns"}, 4);
        compare(since_e0(found, t_a));
        wait_level(1'b0, 40, t_b, found);
        expect_val({pfx, "_first_fall_ns"}, 13 * 8);
        compare(since_e0(found, t_b));
        goto_edge(399);
        expect_val({pfx, "_locked_e0_399"}, 0);
        compare({63'b0, lock_mux});
        goto_edge(400);
        expect_val({pfx, "_locked_e0_400"}, 1);
        compare({63'b0, lock_mux});
    endtask

    initial begin
        resetn_odd    = 1'b0;
        resetn_even   = 1'b0;
        sel_even      = 1'b0;
        lock_low_seen = 1'b0;
        any_out       = 1'b0;
        any_lock      = 1'b0;

        repeat (50) begin
            @(negedge clk);
            #1;
            any_out  = any_out  | clk_out_odd | clk_out_even;
            any_lock = any_lock | locked_odd  | locked_even;
        end
        expect_val("reset_hold_clk_out", 0);
        compare({63'b0, any_out});
        expect_val("reset_hold_locked", 0);
        compare({63'b0, any_lock});

        release_reset(1'b0);
        odd_first_edge_and_lock("odd");

        lock_low_seen = 1'b0;
        wait_level(1'b1, 60, t_a, found);
        for (int i = 0; i < 20; i++) begin
            wait_level(1'b0, 60, t_b, found_b);
            wait_level(1'b1, 60, t_c, found_c);
            expect_val("odd_high_ns", 100);
            compare((found && found_b) ? 64'(t_b - t_a) : '1);
            expect_val("odd_low_ns", 100);
            compare((found_b && found_c) ? 64'(t_c - t_b) : '1);
            expect_val("odd_period_ns", 200);
            compare((found && found_c) ? 64'(t_c - t_a) : '1);
            t_a   = t_c;
            found = found_c;
        end
        goto_edge(1400);
        expect_val("odd_lock_dropped", 0);
        compare({63'b0, lock_low_seen});

        wait_level(1'b1, 60, t_a, found);
        expect_val("midrun_out_high_before_reset", 1);
        compare({63'b0, found});
        #2;
        resetn_odd = 1'b0;
        #0.1;
        expect_val("midrun_clk_out", 0);
        compare({63'b0, clk_out_odd});
        expect_val("midrun_locked", 0);
        compare({63'b0, locked_odd});
        repeat (10) @(posedge clk);
        release_reset(1'b0);
        odd_first_edge_and_lock("rst2");

        sel_even = 1'b1;
        release_reset(1'b1);
        expect_val("even_out_after_e0", 1);
        compare({63'b0, out_mux});
        wait_level(1'b0, 10, t_b, found);
        expect_val("even_first_fall_ns", 2 * 8);
        compare(since_e0(found, t_b));
        for (int i = 0; i < 5; i++) begin
            wait_level(1'b1, 10, t_c, found_c);
            expect_val("even_low_ns", 16);
            compare((found && found_c) ? 64'(t_c - t_b) : '1);
            wait_level(1'b0, 10, t_a, found_b);
            expect_val("even_high_ns", 16);
            compare((found_c && found_b) ? 64'(t_a - t_c) : '1);
            t_b   = t_a;
            found = found_b;
        end
        goto_edge(63);
        expect_val("even_locked_e0_63", 0);
        compare({63'b0, lock_mux});
        goto_edge(64);
        expect_val("even_locked_e0_64", 1);
        compare({63'b0, lock_mux});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clk_5mhz_gen.md
# clk_5mhz_gen

Clock-generation block that derives the 5 MHz system clock from the 125 MHz board oscillator by integer division. It sits at the top of the LED-control design, ahead of the 10 Hz-class rate divider and the LED shift logic, and takes the place of the vendor clocking IP with a portable RTL divider. It produces a 50 %-duty output for odd or even divide ratios and a `locked` flag once the output is stable.

## Interface
Parameters:
- `DIV`, 25: input-to-output divide ratio. Must be ≥ 2; elaboration fails otherwise.
- `LOCK_CYCLES`, 16: number of complete output periods after reset before `locked` asserts. Must be ≥ 1.

Ports:
- `clk_in1`, input, 1: 125 MHz source clock. This is the single clock.
- `resetn`, input, 1: reset. Asynchronous, active-low.
- `clk_out1`, output, 1: divided clock, 5 MHz at the defaults.
- `locked`, output, 1: high once `clk_out1` has run `LOCK_CYCLES` full periods.

## Operation
- Phase counter `cnt`:
  - Width is `$clog2(DIV)`; reset value is 0.
  - On each `clk_in1` rising edge it increments, wrapping from `DIV-1` to 0.
- Rising-edge phase register `ph_p`:
  - Updated on each `clk_in1` rising edge as `ph_p <= (cnt < HIGH)`, where `HIGH = (DIV+1)/2` (13 at the defaults).
  - Reset value is 0.
- Falling-edge phase register `ph_n`:
  - Samples `ph_p` on each `clk_in1` falling edge.
  - Reset value is 0.
- Output selection:
  - Odd `DIV`: `clk_out1 = ph_p & ph_n`. High time is `(DIV-1)/2 + 0.5` input cycles, which is exactly 50 % (100 ns high, 100 ns low at the defaults).
  - Even `DIV`: `clk_out1 = ph_p`, high for `DIV/2` cycles.
  - The output is formed only from registers or an AND of registers. No counter bits or combinational decodes reach `clk_out1`.
- Lock counter:
  - Saturating counter, reset value 0.
  - Increments on each `cnt` wrap (`DIV-1` to 0).
  - `locked` goes high on the `clk_in1` rising edge at which the count reaches `LOCK_CYCLES`, and stays high until `resetn` is asserted.
- Reset values: `clk_out1` = 0, `locked` = 0.
- Reset mid-operation:
  - All state clears immediately and asynchronously.
  - `clk_out1` is forced low at once; a truncated high pulse is acceptable.
  - `locked` drops at once.
- Reset release: deassertion is honoured at the next `clk_in1` rising edge. A release coincident with an edge is treated as taking effect at the following edge.

## Timing
- With `E0` = the first `clk_in1` rising edge after `resetn` deasserts:
  - `ph_p` rises at `E0`.
  - Odd `DIV`: `clk_out1` rises at the falling edge following `E0`, half a cycle later.
  - Even `DIV`: `clk_out1` rises at `E0`.
- `clk_out1` falls at the rising edge `E0 + HIGH` (`E0 + DIV/2` for even `DIV`).
- Output period is exactly `DIV` input cycles: 200 ns at 125 MHz / 25.
- `locked` rises at rising edge `E0 + LOCK_CYCLES*DIV`, which is 400 input cycles at the defaults.
- Frequency and phase are fixed; there is no jitter beyond the duty-cycle distortion of `clk_in1` itself.

## Structure
- No shared-package content is needed. `HIGH` and the counter widths are local parameters derived from `DIV` and `LOCK_CYCLES`.
- One natural sub-module, `clk_lock_cnt`: the saturating period counter that produces `locked`, parameterised by `LOCK_CYCLES`.
- The top level holds the phase counter and both phase registers, and selects the output form with a generate on `DIV % 2`.

## Test plan
- **Reset hold:** hold `resetn` = 0 for 50 `clk_in1` cycles → `clk_out1` = 0 and `locked` = 0 throughout.
- **Default ratio:** release reset with the 8 ns `clk_in1` period → `clk_out1` period is 200 ns; high time is 100 ns ± 0 and low time is 100 ns, measured over 20 periods.
- **First edge:** release reset → first `clk_out1` rise occurs 4 ns after `E0`, and its first fall occurs at `E0 + 13` cycles.
- **Lock:** release reset → `locked` is 0 at `E0 + 399` and 1 at `E0 + 400`, and stays 1 for the next 1000 cycles.
- **Mid-run reset:** assert `resetn` = 0 asynchronously while `clk_out1` is high, between clock edges → `clk_out1` and `locked` go to 0 within the same delta. After release, the timing of the first-edge and lock checks repeats.
- **Even ratio:** `DIV` = 4 → `clk_out1` is high 2 cycles and low 2 cycles, and `locked` rises at `E0 + 64`.
